bayer_mosaic_unit: RTL and testbench
====================================

// Module: bayer_mosaic_unit
// PURPOSE
//  RGB-to-Bayer re-mosaic stage, the inverse of the ISP demosaic path. Takes a 24-bit {R,G,B} pixel stream
//  and emits one 8-bit CFA sample per pixel, selected by row/column parity and the configured CFA order.
//  Feeds RAW capture and write-back, and drives synthetic Bayer into the demosaic input for loopback test.
//  Valid/ready on both sides. Frame and line position tracked by internal counters.
// PARAMETERS
//  MAX_WIDTH   4096  max line length in pixels; sets col counter width = $clog2(MAX_WIDTH)
//  MAX_HEIGHT  4096  max lines per frame; row counter saturates at MAX_HEIGHT-1
// PORTS
//  clk_i            in   1   single clock
//  rst_i            in   1   synchronous, active-high reset
//  cfg_enable_i     in   1   1=mosaic, 0=bypass (G channel passed)
//  cfg_pattern_i    in   2   CFA order: 0=RGGB 1=GRBG 2=GBRG 3=BGGR
//  cfg_width_i      in   13  active line length in pixels (1..MAX_WIDTH)
//  rgb_data_i       in   24  {R[23:16],G[15:8],B[7:0]}
//  rgb_valid_i      in   1   input pixel valid
//  rgb_sof_i        in   1   first pixel of frame, qualified by valid
//  rgb_eol_i        in   1   last pixel of line, qualified by valid
//  rgb_ready_o      out  1   input accept
//  bayer_data_o     out  24  {16'h0, sample[7:0]}, matches demosaic input format
//  bayer_valid_o    out  1   output valid
//  bayer_sof_o      out  1   sideband aligned with bayer_data_o
//  bayer_eol_o      out  1   sideband aligned with bayer_data_o
//  bayer_ready_i    in   1   downstream accept
//  err_line_len_o   out  1   1-cycle pulse on line-length mismatch
// BEHAVIOUR
//  Reset:
//  - All outputs 0 except rgb_ready_o=1.
//  - FSM=IDLE; col=0, row=0; latched pattern/width =0/1.
//  Handshake:
//  - Input accepted when rgb_valid_i & rgb_ready_o.
//  - rgb_ready_o = !bayer_valid_o | bayer_ready_i (single output register, no combinational valid->ready path).
//  - Output holds data and sideband stable while valid & !ready.
//  Latency: 1 cycle from accept to bayer_valid_o; 2 with MOSAIC_WB_GAIN_EN. Full throughput, 1 pixel/clk.
//  FSM:
//  - IDLE: accept and discard every pixel until an accepted pixel has sof; on sof -> ACTIVE.
//  - ACTIVE: each accepted pixel is emitted. An accepted sof pixel re-latches cfg and restarts row=0, col=0.
//  Config: cfg_pattern_i and cfg_width_i are latched only on an accepted sof pixel; mid-frame changes are ignored.
//  Channel select, phase={row[0],col[0]}:
//  - RGGB: 00=R 01=G 10=G 11=B
//  - GRBG: 00=G 01=R 10=B 11=G
//  - GBRG: 00=G 01=B 10=R 11=G
//  - BGGR: 00=B 01=G 10=G 11=R
//  - cfg_enable_i=0: sample=G, counters still run.
//  Counters:
//  - col++ per accepted pixel.
//  - On eol: col=0, row++ (saturating).
//  Boundaries:
//  - eol with col!=width-1: err pulse; counters wrap normally.
//  - col==width-1 without eol: err pulse; col=0, row++ (implicit wrap); output bayer_eol_o=0.
//  - sof with eol on the same pixel (width 1) is legal: both sideband bits are set on the output.
//  - sof mid-line: frame restarts, no error.
//  - rst_i mid-frame: output valid drops next cycle, pending pixel lost, FSM -> IDLE.
// CONFIGURATION
//  MOSAIC_WB_GAIN_EN defined:
//  - Adds cfg_gain_r_i/cfg_gain_g_i/cfg_gain_b_i (12b, Q4.8, 0x100=1.0), latched at sof.
//  - sample=min(255,(px*gain+128)>>8); one extra pipeline stage; ready still driven from last stage.
//  MOSAIC_WB_GAIN_EN undefined: no gain ports, 1-cycle latency, sample=raw channel.
// STRUCTURE
//  isp_pkg:
//  - cfa_pattern_e (RGGB,GRBG,GBRG,BGGR)
//  - PIX_W=8, RGB_W=24, gain Q-format constants
//  - mosaic_state_e (IDLE,ACTIVE)
//  Sub-module isp_pipe_reg: generic valid/ready data+sideband register; one or two instances in series.
// TESTING
//  - RGGB, width 4, 2 lines of rgb=0x112233, ready=1 -> samples 11,22,11,22 / 22,33,22,33; eol on 4th and 8th.
//  - BGGR, same stimulus -> line0 33,22,33,22; line1 22,11,22,11; sof only on first output.
//  - Pixels before first sof -> no bayer_valid_o; first sof pixel appears 1 cycle after accept.
//  - bayer_ready_i=0 for 5 cycles mid-line -> rgb_ready_o=0 within 1 cycle, data stable, no loss or dup.
//  - width 4, eol on 3rd pixel -> err_line_len_o pulse once; next pixel uses row 1 phase.
//  - rst_i mid-line -> all outputs reset next cycle; pixels ignored until next sof.

Source files
------------

// File: rtl/isp_pkg.sv
// Shared types and constants for the ISP pixel path: CFA ordering,
// channel selection, mosaic FSM states and white-balance gain format.
package isp_pkg;

    localparam int PIX_W     = 8;
    localparam int RGB_W     = 24;
    localparam int GAIN_W    = 12;
    localparam int GAIN_FRAC = 8;
    localparam logic [GAIN_W-1:0] GAIN_ONE = 12'h100;
    localparam int GAIN_RND  = 1 << (GAIN_FRAC - 1);

    typedef enum logic [1:0] {
        RGGB = 2'd0,
        GRBG = 2'd1,
        GBRG = 2'd2,
        BGGR = 2'd3
    } cfa_pattern_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } mosaic_state_e;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } cfa_channel_e;

    // Colour channel sampled at phase {row[0], col[0]} for a given CFA order.
    function automatic cfa_channel_e cfa_channel(input cfa_pattern_e pat, input logic [1:0] phase);
        cfa_channel_e ch;
        ch = CH_G;
        case (pat)
            RGGB: ch = (phase == 2'b00) ? CH_R : (phase == 2'b11) ? CH_B : CH_G;
            GRBG: ch = (phase == 2'b01) ? CH_R : (phase == 2'b10) ? CH_B : CH_G;
            GBRG: ch = (phase == 2'b10) ? CH_R : (phase == 2'b01) ? CH_B : CH_G;
            BGGR: ch = (phase == 2'b11) ? CH_R : (phase == 2'b00) ? CH_B : CH_G;
            default: ch = CH_G;
        endcase
        return ch;
    endfunction

    // Extract one 8-bit channel from a packed {R,G,B} pixel.
    function automatic logic [PIX_W-1:0] pick_channel(input logic [RGB_W-1:0] rgb, input cfa_channel_e ch);
        logic [PIX_W-1:0] px;
        case (ch)
            CH_R:    px = rgb[23:16];
            CH_B:    px = rgb[7:0];
            default: px = rgb[15:8];
        endcase
        return px;
    endfunction

    // Q4.8 gain with round-half-up, saturated to the 8-bit sample range.
    function automatic logic [PIX_W-1:0] apply_gain(input logic [PIX_W-1:0] px, input logic [GAIN_W-1:0] gain);
        logic [20:0] acc;
        logic [20:0] sh;
        acc = 21'(px) * 21'(gain) + 21'(GAIN_RND);
        sh  = acc >> GAIN_FRAC;
        return (|sh[20:8]) ? 8'hFF : sh[7:0];
    endfunction

endpackage

// File: rtl/isp_pipe_reg.sv
// Generic valid/ready pipeline register carrying data plus sideband as
// one payload. Accepts a new beat whenever empty or draining downstream.
module isp_pipe_reg #(
    parameter int W = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         in_ready_o,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    input  logic         out_ready_i
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    // Load on a free slot; hold data and valid stable while stalled.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready_o) begin
            valid_d = in_valid_i;
            if (in_valid_i) begin
                data_d = in_data_i;
            end
        end
    end

    // Payload register; reset clears everything so outputs read as zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/bayer_mosaic_unit.sv
// RGB-to-Bayer re-mosaic: emits one CFA sample per accepted pixel, chosen by
// row/column parity and the CFA order latched at start of frame.
// Build option: MOSAIC_WB_GAIN_EN adds per-channel Q4.8 white-balance gain
// and one extra pipeline stage.
module bayer_mosaic_unit
    import isp_pkg::*;
#(
    parameter int MAX_WIDTH  = 4096,
    parameter int MAX_HEIGHT = 4096
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cfg_enable_i,
    input  logic [1:0]          cfg_pattern_i,
    input  logic [12:0]         cfg_width_i,
`ifdef MOSAIC_WB_GAIN_EN
    input  logic [GAIN_W-1:0]   cfg_gain_r_i,
    input  logic [GAIN_W-1:0]   cfg_gain_g_i,
    input  logic [GAIN_W-1:0]   cfg_gain_b_i,
`endif
    input  logic [RGB_W-1:0]    rgb_data_i,
    input  logic                rgb_valid_i,
    input  logic                rgb_sof_i,
    input  logic                rgb_eol_i,
    output logic                rgb_ready_o,
    output logic [RGB_W-1:0]    bayer_data_o,
    output logic                bayer_valid_o,
    output logic                bayer_sof_o,
    output logic                bayer_eol_o,
    input  logic                bayer_ready_i,
    output logic                err_line_len_o
);

    localparam int COL_W = $clog2(MAX_WIDTH);
    localparam int ROW_W = $clog2(MAX_HEIGHT);

    mosaic_state_e     state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d, cur_col;
    logic [ROW_W-1:0]  row_q, row_d, cur_row, row_inc;
    cfa_pattern_e      pat_q, pat_d, pat_cur;
    logic [12:0]       wid_q, wid_d, wid_cur;
    logic              err_q, err_d;
    logic              accept, emit, line_end;
    cfa_channel_e      ch;
    logic [PIX_W-1:0]  px;
    logic [PIX_W-1:0]  sample;
    logic              out_sof, out_eol;

    assign accept = rgb_valid_i && rgb_ready_o;

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: any accepted sof (re)starts a frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && rgb_sof_i) state_d = ACTIVE;
            ACTIVE:  state_d = ACTIVE;
            default: state_d = IDLE;
        endcase
    end

    // FSM output: pixels before the first sof are accepted and dropped.
    always_comb begin
        emit = 1'b0;
        case (state_q)
            IDLE:    emit = accept && rgb_sof_i;
            ACTIVE:  emit = accept;
            default: emit = 1'b0;
        endcase
    end

    // Position, config latch, line-length check and channel pick for the current pixel.
    always_comb begin
        // An sof pixel sits at (0,0) and uses the config presented with it.
        cur_col  = rgb_sof_i ? '0 : col_q;
        cur_row  = rgb_sof_i ? '0 : row_q;
        pat_cur  = rgb_sof_i ? cfa_pattern_e'(cfg_pattern_i) : pat_q;
        wid_cur  = rgb_sof_i ? cfg_width_i : wid_q;
        line_end = (13'(cur_col) == (wid_cur - 13'd1));
        row_inc  = (cur_row == ROW_W'(MAX_HEIGHT - 1)) ? cur_row : cur_row + ROW_W'(1);

        col_d = col_q;
        row_d = row_q;
        pat_d = pat_q;
        wid_d = wid_q;
        err_d = 1'b0;
        if (emit) begin
            // Explicit eol or reaching the configured width both end the line.
            if (rgb_eol_i || line_end) begin
                col_d = '0;
                row_d = row_inc;
            end else begin
                col_d = cur_col + COL_W'(1);
                row_d = cur_row;
            end
            err_d = rgb_eol_i ^ line_end;
            if (rgb_sof_i) begin
                pat_d = pat_cur;
                wid_d = wid_cur;
            end
        end

        ch = cfg_enable_i ? cfa_channel(pat_cur, {cur_row[0], cur_col[0]}) : CH_G;
        px = pick_channel(rgb_data_i, ch);
    end

    // Counter, latched config and error pulse registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_q <= '0;
            row_q <= '0;
            pat_q <= RGGB;
            wid_q <= 13'd1;
            err_q <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            pat_q <= pat_d;
            wid_q <= wid_d;
            err_q <= err_d;
        end
    end

    assign err_line_len_o = err_q;

`ifdef MOSAIC_WB_GAIN_EN
    logic [GAIN_W-1:0] gain_r_q, gain_g_q, gain_b_q;
    logic [GAIN_W-1:0] gain_r_d, gain_g_d, gain_b_d;
    logic [GAIN_W-1:0] gain_cur;
    logic [PIX_W+GAIN_W+1:0] a_data;
    logic              a_valid, a_ready, b_ready;
    logic [PIX_W+1:0]  b_in, b_data;

    // Gain for the selected channel, taken from the sof pixel's inputs when starting a frame.
    always_comb begin
        gain_r_d = (emit && rgb_sof_i) ? cfg_gain_r_i : gain_r_q;
        gain_g_d = (emit && rgb_sof_i) ? cfg_gain_g_i : gain_g_q;
        gain_b_d = (emit && rgb_sof_i) ? cfg_gain_b_i : gain_b_q;
        case (ch)
            CH_R:    gain_cur = rgb_sof_i ? cfg_gain_r_i : gain_r_q;
            CH_B:    gain_cur = rgb_sof_i ? cfg_gain_b_i : gain_b_q;
            default: gain_cur = rgb_sof_i ? cfg_gain_g_i : gain_g_q;
        endcase
    end

    // Latched gains; unity after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gain_r_q <= GAIN_ONE;
            gain_g_q <= GAIN_ONE;
            gain_b_q <= GAIN_ONE;
        end else begin
            gain_r_q <= gain_r_d;
            gain_g_q <= gain_g_d;
            gain_b_q <= gain_b_d;
        end
    end

    isp_pipe_reg #(.W(PIX_W + GAIN_W + 2)) u_stage_a (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (emit),
        .in_data_i   ({rgb_sof_i, rgb_eol_i, px, gain_cur}),
        .in_ready_o  (a_ready),
        .out_valid_o (a_valid),
        .out_data_o  (a_data),
        .out_ready_i (b_ready)
    );

    assign b_in = {a_data[PIX_W+GAIN_W+1], a_data[PIX_W+GAIN_W],
                   apply_gain(a_data[PIX_W+GAIN_W-1:GAIN_W], a_data[GAIN_W-1:0])};

    isp_pipe_reg #(.W(PIX_W + 2)) u_stage_b (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (a_valid),
        .in_data_i   (b_in),
        .in_ready_o  (b_ready),
        .out_valid_o (bayer_valid_o),
        .out_data_o  (b_data),
        .out_ready_i (bayer_ready_i)
    );

    // b_ready already implies a_ready; the AND keeps intake tied to the last stage.
    assign rgb_ready_o = a_ready && b_ready;
    assign {out_sof, out_eol, sample} = b_data;
`else
    logic [PIX_W+1:0] s_data;

    isp_pipe_reg #(.W(PIX_W + 2)) u_stage (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (emit),
        .in_data_i   ({rgb_sof_i, rgb_eol_i, px}),
        .in_ready_o  (rgb_ready_o),
        .out_valid_o (bayer_valid_o),
        .out_data_o  (s_data),
        .out_ready_i (bayer_ready_i)
    );

    assign {out_sof, out_eol, sample} = s_data;
`endif

    assign bayer_data_o = {16'h0000, sample};
    assign bayer_sof_o  = out_sof;
    assign bayer_eol_o  = out_eol;

endmodule

// File: tb/tb_bayer_mosaic_unit.sv
// Directed bench for bayer_mosaic_unit: table of per-pixel vectors plus
// hand-written backpressure and mid-line reset sequences.
module tb_bayer_mosaic_unit;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        cfg_enable_i;
    logic [1:0]  cfg_pattern_i;
    logic [12:0] cfg_width_i;
    logic [23:0] rgb_data_i;
    logic        rgb_valid_i, rgb_sof_i, rgb_eol_i;
    logic        rgb_ready_o;
    logic [23:0] bayer_data_o;
    logic        bayer_valid_o, bayer_sof_o, bayer_eol_o;
    logic        bayer_ready_i;
    logic        err_line_len_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bayer_mosaic_unit dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .cfg_enable_i   (cfg_enable_i),
        .cfg_pattern_i  (cfg_pattern_i),
        .cfg_width_i    (cfg_width_i),
        .rgb_data_i     (rgb_data_i),
        .rgb_valid_i    (rgb_valid_i),
        .rgb_sof_i      (rgb_sof_i),
        .rgb_eol_i      (rgb_eol_i),
        .rgb_ready_o    (rgb_ready_o),
        .bayer_data_o   (bayer_data_o),
        .bayer_valid_o  (bayer_valid_o),
        .bayer_sof_o    (bayer_sof_o),
        .bayer_eol_o    (bayer_eol_o),
        .bayer_ready_i  (bayer_ready_i),
        .err_line_len_o (err_line_len_o)
    );

    typedef struct {
        logic        en;
        logic [1:0]  pat;
        logic [12:0] wid;
        logic [23:0] rgb;
        logic        vld;
        logic        sof;
        logic        eol;
        logic        ev;
        logic [7:0]  ed;
        logic        es;
        logic        ee;
        logic        eerr;
    } vec_t;

    vec_t vq[$];

    localparam logic [23:0] PX = 24'h112233;
    localparam logic [23:0] PY = 24'hAABBCC;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic en, input logic [1:0] pat, input logic [12:0] wid,
                       input logic [23:0] rgb, input logic vld, input logic sof, input logic eol,
                       input logic ev, input logic [7:0] ed, input logic es, input logic ee,
                       input logic eerr);
        vec_t v;
        v.en = en; v.pat = pat; v.wid = wid; v.rgb = rgb;
        v.vld = vld; v.sof = sof; v.eol = eol;
        v.ev = ev; v.ed = ed; v.es = es; v.ee = ee; v.eerr = eerr;
        vq.push_back(v);
    endtask

    task automatic drive(input logic en, input logic [1:0] pat, input logic [12:0] wid,
                         input logic [23:0] rgb, input logic vld, input logic sof, input logic eol);
        cfg_enable_i  = en;
        cfg_pattern_i = pat;
        cfg_width_i   = wid;
        rgb_data_i    = rgb;
        rgb_valid_i   = vld;
        rgb_sof_i     = sof;
        rgb_eol_i     = eol;
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [7:0] ed,
                           input logic es, input logic ee, input logic eerr);
        chk({tag, ".valid"}, 32'(bayer_valid_o), 32'(ev));
        if (ev) begin
            chk({tag, ".data"}, 32'(bayer_data_o), {8'h0, 16'h0, ed});
            chk({tag, ".sof"},  32'(bayer_sof_o),  32'(es));
            chk({tag, ".eol"},  32'(bayer_eol_o),  32'(ee));
        end
        chk({tag, ".err"}, 32'(err_line_len_o), 32'(eerr));
    endtask

    initial begin
        rst_i = 1'b1;
        bayer_ready_i = 1'b1;
        drive(1'b1, 2'd0, 13'd4, PX, 1'b0, 1'b0, 1'b0);

        // Pre-sof pixels are dropped, then a gap.
        add(1, 0, 4, PX, 1, 0, 0,   0, 8'h00, 0, 0, 0);
        add(1, 0, 4, PX, 1, 0, 1,   0, 8'h00, 0, 0, 0);
        add(1, 0, 4, PX, 0, 0, 0,   0, 8'h00, 0, 0, 0);
        // RGGB width 4, two lines.
        add(1, 0, 4, PX, 1, 1, 0,   1, 8'h11, 1, 0, 0);
        add(1, 0, 4, PX, 1, 0, 0,   1, 8'h22, 0, 0, 0);
        add(1, 0, 4, PX, 1, 0, 0,   1, 8'h11, 0, 0, 0);
        add(1, 0, 4, PX, 1, 0, 1,   1, 8'h22, 0, 1, 0);
        add(1, 0, 4, PX, 1, 0, 0,   1, 8'h22, 0, 0, 0);
        add(1, 0, 4, PX, 1, 0, 0,   1, 8'h33, 0, 0, 0);
        add(1, 0, 4, PX, 1, 0, 0,   1, 8'h22, 0, 0, 0);
        add(1, 0, 4, PX, 1, 0, 1,   1, 8'h33, 0, 1, 0);
        add(1, 0, 4, PX, 0, 0, 0,   0, 8'h00, 0, 0, 0);
        // BGGR; pattern input changes mid-frame and must be ignored.
        add(1, 3, 4, PX, 1, 1, 0,   1, 8'h33, 1, 0, 0);
        add(1, 3, 4, PX, 1, 0, 0,   1, 8'h22, 0, 0, 0);
        add(1, 0, 4, PX, 1, 0, 0,   1, 8'h33, 0, 0, 0);
        add(1, 0, 4, PX, 1, 0, 1,   1, 8'h22, 0, 1, 0);
        add(1, 0, 4, PX, 1, 0, 0,   1, 8'h22, 0, 0, 0);
        add(1, 0, 9, PX, 1, 0, 0,   1, 8'h11, 0, 0, 0);
        add(1, 0, 9, PX, 1, 0, 0,   1, 8'h22, 0, 0, 0);
        add(1, 0, 9, PX, 1, 0, 1,   1, 8'h11, 0, 1, 0);
        // RGGB: early eol, then implicit wrap without eol.
        add(1, 0, 4, PX, 1, 1, 0,   1, 8'h11, 1, 0, 0);
        add(1, 0, 4, PX, 1, 0, 0,   1, 8'h22, 0, 0, 0);
        add(1, 0, 4, PX, 1, 0, 1,   1, 8'h11, 0, 1, 1);
        add(1, 0, 4, PX, 1, 0, 0,   1, 8'h22, 0, 0, 0);
        add(1, 0, 4, PX, 1, 0, 0,   1, 8'h33, 0, 0, 0);
        add(1, 0, 4, PX, 1, 0, 0,   1, 8'h22, 0, 0, 0);
        add(1, 0, 4, PX, 1, 0, 0,   1, 8'h33, 0, 0, 1);
        add(1, 0, 4, PX, 1, 0, 0,   1, 8'h11, 0, 0, 0);
        // GRBG width 1: sof+eol on one pixel, then single-pixel lines.
        add(1, 1, 1, PX, 1, 1, 1,   1, 8'h22, 1, 1, 0);
        add(1, 1, 1, PX, 1, 0, 1,   1, 8'h33, 0, 1, 0);
        add(1, 1, 1, PX, 1, 0, 1,   1, 8'h22, 0, 1, 0);
        // Bypass passes G while counters keep running.
        add(0, 0, 4, PY, 1, 1, 0,   1, 8'hBB, 1, 0, 0);
        add(1, 0, 4, PY, 1, 0, 0,   1, 8'hBB, 0, 0, 0);
        add(1, 0, 4, PY, 1, 0, 0,   1, 8'hAA, 0, 0, 0);
        add(0, 0, 4, PY, 1, 0, 1,   1, 8'hBB, 0, 1, 0);
        // sof mid-line restarts the frame with new config, no error.
        add(1, 0, 4, PX, 1, 1, 0,   1, 8'h11, 1, 0, 0);
        add(1, 0, 4, PX, 1, 0, 0,   1, 8'h22, 0, 0, 0);
        add(1, 2, 4, PX, 1, 1, 0,   1, 8'h22, 1, 0, 0);
        add(1, 2, 4, PX, 1, 0, 0,   1, 8'h33, 0, 0, 0);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("reset.data", 32'(bayer_data_o), 32'h0);
        chk("reset.sof", 32'(bayer_sof_o), 32'h0);
        chk("reset.eol", 32'(bayer_eol_o), 32'h0);
        chk("reset.ready", 32'(rgb_ready_o), 32'h1);
        @(negedge clk);
        rst_i = 1'b0;

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].en, vq[i].pat, vq[i].wid, vq[i].rgb, vq[i].vld, vq[i].sof, vq[i].eol);
            #1;
            chk($sformatf("v%0d.ready", i), 32'(rgb_ready_o), 32'h1);
            @(posedge clk);
            #1;
            chk_out($sformatf("v%0d", i), vq[i].ev, vq[i].ed, vq[i].es, vq[i].ee, vq[i].eerr);
        end

        // Backpressure mid-line: output holds, intake stalls, nothing lost or duplicated.
        @(negedge clk);
        drive(1, 0, 4, PX, 1, 1, 0);
        @(posedge clk);
        #1;
        chk_out("bp.p0", 1, 8'h11, 1, 0, 0);
        @(negedge clk);
        bayer_ready_i = 1'b0;
        drive(1, 0, 4, PX, 1, 0, 0);
        #1;
        chk("bp.ready_low", 32'(rgb_ready_o), 32'h0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk_out($sformatf("bp.hold%0d", k), 1, 8'h11, 1, 0, 0);
            chk($sformatf("bp.hold%0d.ready", k), 32'(rgb_ready_o), 32'h0);
        end
        @(negedge clk);
        bayer_ready_i = 1'b1;
        #1;
        chk("bp.ready_high", 32'(rgb_ready_o), 32'h1);
        @(posedge clk);
        #1;
        chk_out("bp.p1", 1, 8'h22, 0, 0, 0);
        @(negedge clk);
        drive(1, 0, 4, PX, 1, 0, 0);
        @(posedge clk);
        #1;
        chk_out("bp.p2", 1, 8'h11, 0, 0, 0);
        @(negedge clk);
        drive(1, 0, 4, PX, 1, 0, 1);
        @(posedge clk);
        #1;
        chk_out("bp.p3", 1, 8'h22, 0, 1, 0);

        // Reset mid-line: outputs clear next cycle, non-sof pixels then dropped.
        @(negedge clk);
        drive(1, 0, 4, PX, 1, 0, 0);
        @(negedge clk);
        rst_i = 1'b1;
        drive(1, 0, 4, PX, 1, 0, 1);
        @(posedge clk);
        #1;
        chk("rst.valid", 32'(bayer_valid_o), 32'h0);
        chk("rst.data", 32'(bayer_data_o), 32'h0);
        chk("rst.sof", 32'(bayer_sof_o), 32'h0);
        chk("rst.eol", 32'(bayer_eol_o), 32'h0);
        chk("rst.err", 32'(err_line_len_o), 32'h0);
        chk("rst.ready", 32'(rgb_ready_o), 32'h1);
        @(negedge clk);
        rst_i = 1'b0;
        drive(1, 0, 4, PX, 1, 0, 0);
        @(posedge clk);
        #1;
        chk_out("rst.drop0", 0, 8'h00, 0, 0, 0);
        @(negedge clk);
        drive(1, 0, 4, PX, 1, 0, 1);
        @(posedge clk);
        #1;
        chk_out("rst.drop1", 0, 8'h00, 0, 0, 0);
        @(negedge clk);
        drive(1, 3, 4, PX, 1, 1, 0);
        @(posedge clk);
        #1;
        chk_out("rst.resume", 1, 8'h33, 1, 0, 0);
        @(negedge clk);
        drive(1, 3, 4, PX, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_out("rst.idle", 0, 8'h00, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
